pc_gen_multi: RTL
=================

PC_GEN_MULTI -- requirements
Module: pc_gen_multi

Interface
REQ-001 SHALL have parameter FETCH_WIDTH, default 2, instructions per fetch group (1, 2, 4 or 8).
REQ-002 SHALL have parameter RESET_VECTOR, default 32'hBFC0_0000, PC after reset.
REQ-003 SHALL have parameter CNT_W, default $clog2(FETCH_WIDTH)+1, width of lane counts.
REQ-004 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-005 SHALL have port rst, input, 1, synchronous active-high reset.
REQ-006 SHALL have port hold_pc, input, 1, pipeline stall; freezes pc and status.
REQ-007 SHALL have port taken_cnt, input, CNT_W, instructions consumed from the current group this cycle.
REQ-008 SHALL have port jump, input, 1, branch redirect request.
REQ-009 SHALL have port jump_to, input, 32, branch target.
REQ-010 SHALL have port flush, input, 1, exception redirect request.
REQ-011 SHALL have port flush_pc, input, 32, exception target.
REQ-012 SHALL have port ce, output, 1, fetch enable.
REQ-013 SHALL have port is_hard_reset, output, 1, high in the first fetch cycle after any redirect.
REQ-014 SHALL have port pc, output, 32, current fetch address.
REQ-015 SHALL have port fetch_mask, output, FETCH_WIDTH, valid lanes of the aligned group containing pc.
REQ-016 SHALL have port pend_valid, output, 1, a redirect is latched while stalled.
REQ-017 SHALL have port pc_misalign, output, 1, fetch address not word-aligned.

Function
REQ-018 SHALL register ce as the inverse of rst (ce goes high one cycle after rst falls).
REQ-019 SHALL load pc with RESET_VECTOR and status HARD_SET on every cycle ce==0.
REQ-020 SHALL use status states HARD_SET and RUN; is_hard_reset = (status==HARD_SET).
REQ-021 SHALL apply priority, for ce==1: flush > jump > hold_pc > advance.
REQ-022 SHALL, when hold_pc==0 and flush==1: pc <= flush_pc, status <= HARD_SET, pending cleared.
REQ-023 SHALL, when hold_pc==0, flush==0, jump==1: pc <= jump_to, status <= HARD_SET, pending cleared.
REQ-024 SHALL, when hold_pc==1 and flush or jump: leave pc/status unchanged, latch the target into the pending register, and set pend_valid next cycle.
REQ-025 SHALL let a later stalled flush overwrite a pending jump; a later stalled jump SHALL NOT overwrite a pending flush.
REQ-026 SHALL, on the first cycle with hold_pc==0 and pend_valid==1 and no new flush/jump: pc <= pending target, status <= HARD_SET, pend_valid <= 0.
REQ-027 SHALL, in HARD_SET with no redirect and hold_pc==0: keep pc and go to RUN.
REQ-028 SHALL, in RUN with no redirect and hold_pc==0: pc <= pc + 4*min(taken_cnt, popcount(fetch_mask)); status stays RUN.
REQ-029 SHALL drive fetch_mask[i]=1 for i >= pc[$clog2(FETCH_WIDTH)+1:2], else 0 (all ones when FETCH_WIDTH==1).
REQ-030 SHALL wrap pc modulo 2^32 on addition without any flag.
REQ-031 SHALL treat taken_cnt==0 in RUN as pc unchanged.

Reset
REQ-032 SHALL, while rst==1 at a clock edge, set ce=0, status=HARD_SET, pend_valid=0, pending target=0; pc becomes RESET_VECTOR on the following edge (ce==0).
REQ-033 SHALL let rst asserted mid-stall discard any pending redirect.

Configuration
REQ-034 SHALL, with macro PC_ALIGN_CHECK_EN defined, drive pc_misalign = (pc[1:0]!=0) and suppress advance in RUN while misaligned; flush/jump still redirect.
REQ-035 SHALL, without PC_ALIGN_CHECK_EN, tie pc_misalign to 0 and never suppress advance.

Verification
REQ-036 Reset: rst 3 cycles then low -> ce=0 first cycle, pc=0xBFC00000, is_hard_reset=1, then RUN; taken_cnt=2 gives pc 0xBFC00008.
REQ-037 Partial take: FETCH_WIDTH=2, pc=0x80000000 RUN, taken_cnt=1 -> pc=0x80000004, fetch_mask=2'b10; next taken_cnt=2 -> pc=0x80000008 (clamped to 1 lane).
REQ-038 Stalled redirect: hold_pc=1, jump to 0x80001000, then flush to 0xBFC00380 -> pend_valid=1; hold_pc=0 -> pc=0xBFC00380, is_hard_reset=1, pend_valid=0.
REQ-039 Simultaneous: flush (0xBFC00380) and jump (0x80002000) same cycle, no hold -> pc=0xBFC00380.
REQ-040 Wrap: pc=0xFFFFFFFC RUN, taken_cnt=1 -> pc=0x00000000.
REQ-041 With PC_ALIGN_CHECK_EN, jump_to=0x80000002 -> pc_misalign=1, pc holds under taken_cnt=2; flush to 0xBFC00380 clears it.

Source files
------------

// File: rtl/pc_gen_multi.sv
`default_nettype none
// ============================================================================
// Module      : pc_gen_multi
// Description : Multi-issue fetch PC generator with stall-safe redirect
//               latching and partial fetch-group consumption.
//               Optional macro PC_ALIGN_CHECK_EN enables misalignment checking.
// Revision    : 1.0 - initial release
// ============================================================================
module pc_gen_multi #(
    parameter int          FETCH_WIDTH  = 2,
    parameter logic [31:0] RESET_VECTOR = 32'hBFC0_0000,
    parameter int          CNT_W        = $clog2(FETCH_WIDTH) + 1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   hold_pc,
    input  logic [CNT_W-1:0]       taken_cnt,
    input  logic                   jump,
    input  logic [31:0]            jump_to,
    input  logic                   flush,
    input  logic [31:0]            flush_pc,
    output logic                   ce,
    output logic                   is_hard_reset,
    output logic [31:0]            pc,
    output logic [FETCH_WIDTH-1:0] fetch_mask,
    output logic                   pend_valid,
    output logic                   pc_misalign
);

    localparam int c_IDX_W = (FETCH_WIDTH > 1) ? $clog2(FETCH_WIDTH) : 1;

    typedef enum logic [0:0] {
        HARD_SET = 1'b0,
        RUN      = 1'b1
    } status_t;

    logic        r_ce;
    status_t     r_status;
    status_t     w_status_nxt;
    logic [31:0] r_pc;
    logic [31:0] w_pc_nxt;
    logic        r_pend_valid;
    logic        w_pend_valid_nxt;
    logic [31:0] r_pend_pc;
    logic [31:0] w_pend_pc_nxt;
    logic        r_pend_flush;
    logic        w_pend_flush_nxt;

    logic [CNT_W-1:0] w_avail;
    logic [CNT_W-1:0] w_take;
    logic [31:0]      w_step;
    logic             w_misalign;

    // Lanes below the pc's slot in the aligned group are not valid this fetch
    generate
        if (FETCH_WIDTH > 1) begin : g_multi
            logic [c_IDX_W-1:0] w_lane_idx;
            assign w_lane_idx = r_pc[c_IDX_W+1:2];
            for (genvar i = 0; i < FETCH_WIDTH; i++) begin : g_mask
                assign fetch_mask[i] = (w_lane_idx <= c_IDX_W'(i));
            end
            assign w_avail = CNT_W'(FETCH_WIDTH) - CNT_W'(w_lane_idx);
        end else begin : g_single
            assign fetch_mask = '1;
            assign w_avail    = CNT_W'(1);
        end
    endgenerate

    assign w_take = (taken_cnt < w_avail) ? taken_cnt : w_avail;
    assign w_step = 32'(w_take) << 2;

`ifdef PC_ALIGN_CHECK_EN
    assign w_misalign = |r_pc[1:0];
`else
    assign w_misalign = 1'b0;
`endif

    always_comb begin
        w_status_nxt     = r_status;
        w_pc_nxt         = r_pc;
        w_pend_valid_nxt = r_pend_valid;
        w_pend_pc_nxt    = r_pend_pc;
        w_pend_flush_nxt = r_pend_flush;
        if (!r_ce) begin
            w_pc_nxt         = RESET_VECTOR;
            w_status_nxt     = HARD_SET;
            w_pend_valid_nxt = 1'b0;
            w_pend_pc_nxt    = '0;
            w_pend_flush_nxt = 1'b0;
        end else if (!hold_pc) begin
            // Any unstalled cycle consumes or supersedes the pending redirect
            w_pend_valid_nxt = 1'b0;
            w_pend_pc_nxt    = '0;
            w_pend_flush_nxt = 1'b0;
            if (flush) begin
                w_pc_nxt     = flush_pc;
                w_status_nxt = HARD_SET;
            end else if (jump) begin
                w_pc_nxt     = jump_to;
                w_status_nxt = HARD_SET;
            end else if (r_pend_valid) begin
                w_pc_nxt     = r_pend_pc;
                w_status_nxt = HARD_SET;
            end else if (r_status == HARD_SET) begin
                w_status_nxt = RUN;
            end else if (!w_misalign) begin
                w_pc_nxt = r_pc + w_step;
            end
        end else begin
            // A pending flush outranks any later stalled jump
            if (flush) begin
                w_pend_valid_nxt = 1'b1;
                w_pend_pc_nxt    = flush_pc;
                w_pend_flush_nxt = 1'b1;
            end else if (jump && !(r_pend_valid && r_pend_flush)) begin
                w_pend_valid_nxt = 1'b1;
                w_pend_pc_nxt    = jump_to;
                w_pend_flush_nxt = 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_ce         <= 1'b0;
            r_status     <= HARD_SET;
            r_pc         <= RESET_VECTOR;
            r_pend_valid <= 1'b0;
            r_pend_pc    <= '0;
            r_pend_flush <= 1'b0;
        end else begin
            r_ce         <= 1'b1;
            r_status     <= w_status_nxt;
            r_pc         <= w_pc_nxt;
            r_pend_valid <= w_pend_valid_nxt;
            r_pend_pc    <= w_pend_pc_nxt;
            r_pend_flush <= w_pend_flush_nxt;
        end
    end

    assign ce            = r_ce;
    assign is_hard_reset = (r_status == HARD_SET);
    assign pc            = r_pc;
    assign pend_valid    = r_pend_valid;
    assign pc_misalign   = w_misalign;

endmodule
`default_nettype wire
